// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// An owner keeps the transmitter for a whole message; a stalled owner loses it after HOLD_MAX cycles.
module uart_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int HOLD_MAX = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  output logic               arb_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick;
  logic            pick_found;
  logic [SW-1:0]   stall_cnt;
  logic            last_flag;
  logic            handshake;
  logic            stall_expire;
  logic            release_now;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        pick       = PW'((int'(rr_ptr) + i) % N_REQ);
        pick_found = 1'b1;
      end
    end
  end

  assign handshake    = (state == LOAD) && req_valid[owner] && !tx_busy;
  assign stall_expire = (state == LOAD) && !handshake && (stall_cnt == SW'(HOLD_MAX - 1));
  assign release_now  = ((state == WAIT_DONE) && !tx_busy && last_flag) || stall_expire;
  assign req_ready    = grant & {N_REQ{handshake}};
  assign tx_start     = (state == START);
  assign arb_busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (pick_found) state_next = LOAD;
      LOAD: begin
        if (handshake)         state_next = START;
        else if (stall_expire) state_next = IDLE;
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = last_flag ? IDLE : LOAD;
      default:   state_next = IDLE;
    endcase
  end

  // Release (end of message or stall timeout) takes priority over the stall increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
      tx_byte   <= 8'h00;
      last_flag <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && pick_found) begin
        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
        owner <= pick;
      end
      if (handshake) begin
        tx_byte   <= req_data[{owner, 3'b000} +: 8];
        last_flag <= req_last[owner];
        stall_cnt <= '0;
      end else if (state == LOAD) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
      if (release_now) begin
        grant     <= '0;
        stall_cnt <= '0;
        rr_ptr    <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, a stub UART core with a 10-cycle busy window,
// and a scoreboard of expected transmitted bytes popped on every tx_start.
module tb_uart_tx_arbiter;

  localparam int N_REQ    = 2;
  localparam int HOLD_MAX = 1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;

  logic [N_REQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N_REQ-1:0] req_data;
  logic               tx_start, tx_busy, arb_busy;
  logic [7:0]         tx_byte;

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};

  logic [3:0] busy_cnt   = 4'd0;
  logic       start_seen = 1'b0;

  int total = 0, bad = 0, cyc = 0, last_start = 0, rdy0 = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_arbiter #(.N_REQ(N_REQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART core stub: registers start, then stays busy for exactly 10 cycles; unaffected by reset.
  always @(posedge clk) begin
    if (start_seen) busy_cnt <= 4'd10;
    else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    start_seen <= tx_start;
  end
  assign tx_busy = (busy_cnt != 4'd0);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input string msg, input bit last);
    logic [8:0] e;
    for (int i = 0; i < msg.len(); i++) begin
      e = {(last && (i == msg.len() - 1)), msg[i]};
      if (r == 0) q0.push_back(e);
      else        q1.push_back(e);
      exp_q.push_back(msg[i]);
    end
  endtask

  task automatic waitDrain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !arb_busy && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  // Requester 0: presents queue head; pops when accepted at the previous edge.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = req_ready[0] && req_valid[0];
      @(posedge clk);
      #1;
      if (acc) void'(q0.pop_front());
      if (q0.size() > 0) begin
        v0 = 1'b1; d0 = q0[0][7:0]; l0 = q0[0][8];
      end else begin
        v0 = 1'b0; l0 = 1'b0;
      end
    end
  end

  // Requester 1.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = req_ready[1] && req_valid[1];
      @(posedge clk);
      #1;
      if (acc) void'(q1.pop_front());
      if (q1.size() > 0) begin
        v1 = 1'b1; d1 = q1[0][7:0]; l1 = q1[0][8];
      end else begin
        v1 = 1'b0; l1 = 1'b0;
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (req_ready[0]) rdy0++;
      if (req_ready != 2'b00) checkOutput("ready_not_owner", 32'(req_ready & ~grant), 32'd0);
      if (tx_start) begin
        checkOutput("start_while_busy", 32'(tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("extra_byte", 32'(tx_byte), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_byte", 32'(tx_byte), 32'(e));
        end
        start_q.push_back(cyc);
        last_start = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    bit ok;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset state checks");
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("rst_arb_busy", 32'(arb_busy), 32'd0);

    $display("[TB] single requester message");
    rdy0 = 0;
    start_q.delete();
    applyStimulus(0, "OK\015\012", 1'b1);
    @(negedge clk);
    checkOutput("t1_not_yet_granted", 32'(grant), 32'd0);
    @(negedge clk);
    checkOutput("t1_grant_latency", 32'(grant), 32'b01);
    checkOutput("t1_ready_in_load", 32'(req_ready), 32'b01);
    waitDrain("t1");
    checkOutput("t1_ready_pulses", 32'(rdy0), 32'd4);
    checkOutput("t1_grant_released", 32'(grant), 32'd0);
    checkOutput("t1_start_count", 32'(start_q.size()), 32'd4);
    for (int i = 1; i < start_q.size(); i++)
      checkOutput("t1_start_spacing", 32'(start_q[i] - start_q[i-1]), 32'd14);

    $display("[TB] simultaneous requests and rotation");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, "A\015\012", 1'b1);
    applyStimulus(1, "B\015\012", 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_first_owner", 32'(grant), 32'b01);
    waitDrain("t2_ab");
    rdy0 = 0;
    applyStimulus(0, "X", 1'b1);
    waitDrain("t2_single");
    checkOutput("t2_single_ready", 32'(rdy0), 32'd1);
    applyStimulus(1, "B\015\012", 1'b1);
    applyStimulus(0, "A\015\012", 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_rotated_owner", 32'(grant), 32'b10);
    waitDrain("t2_ba");

    $display("[TB] late requester waits for whole message");
    applyStimulus(0, "ABCD", 1'b1);
    repeat (20) @(negedge clk);
    applyStimulus(1, "Z", 1'b1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (grant == 2'b00) break;
    end
    checkOutput("t3_release", 32'(grant), 32'd0);
    checkOutput("t3_pending_bytes", 32'(exp_q.size()), 32'd1);
    @(negedge clk);
    checkOutput("t3_regrant", 32'(grant), 32'b10);
    waitDrain("t3");

    $display("[TB] stalled owner loses grant");
    applyStimulus(0, "P", 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    checkOutput("t4_first_byte_sent", 32'(ok), 32'd1);
    s = last_start;
    applyStimulus(1, "W", 1'b1);
    while (cyc < s + 1012) @(negedge clk);
    checkOutput("t4_still_owned", 32'(grant), 32'b01);
    checkOutput("t4_still_busy", 32'(arb_busy), 32'd1);
    @(negedge clk);
    checkOutput("t4_revoked", 32'(grant), 32'd0);
    checkOutput("t4_idle", 32'(arb_busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_waiter_granted", 32'(grant), 32'b10);
    waitDrain("t4_w");
    applyStimulus(0, "R", 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_fresh_grant", 32'(grant), 32'b01);
    waitDrain("t4_r");

    $display("[TB] reset during a frame");
    applyStimulus(0, "MN", 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_busy) begin ok = 1'b1; break; end
    end
    checkOutput("t5_frame_started", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t5_grant_cleared", 32'(grant), 32'd0);
    checkOutput("t5_no_start", 32'(tx_start), 32'd0);
    checkOutput("t5_arb_idle", 32'(arb_busy), 32'd0);
    checkOutput("t5_tx_byte_cleared", 32'(tx_byte), 32'd0);
    @(negedge clk);
    checkOutput("t5_regrant", 32'(grant), 32'b01);
    checkOutput("t5_refuse_while_busy", 32'(req_ready), 32'd0);
    waitDrain("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
